if_fetch: RTL and testbench
===========================

# if_fetch

Instruction-fetch stage of the five-stage LoongArch pipeline. It sits directly upstream of the decode stage. It owns the fetch PC and drives the SRAM-like instruction-memory interface with at most one request outstanding. It hands `{inst, pc}` to decode through the valid/ready_go/allow_in handshake. It applies redirects from three sources: decode branches (`BR_BUS`), WB exceptions, and `ertn`. Requests already in flight are cancelled safely.

## Interface
Parameters:
- `RESET_PC`, 32'h1c000000, address of the first fetch after reset.

Ports:
- `clk`  in  1  — the block's single clock.
- `reset`  in  1  — synchronous, active-high.
- `ID_allow_in`  in  1  — decode can accept an instruction this cycle.
- `BR_BUS`  in  33  — branch bus, `{br_target[32:1], br_taken[0]}`.
- `wb_ex`  in  1  — exception flush from WB.
- `ex_entry`  in  32  — exception entry address.
- `ertn_flush`  in  1  — `ertn` flush from WB.
- `era`  in  32  — return address for `ertn`.
- `inst_sram_req`  out  1  — fetch request.
- `inst_sram_wr`  out  1  — constant 0.
- `inst_sram_size`  out  2  — constant 2'b10.
- `inst_sram_wstrb`  out  4  — constant 0.
- `inst_sram_wdata`  out  32  — constant 0.
- `inst_sram_addr`  out  32  — equals `fetch_pc`.
- `inst_sram_addr_ok`  in  1  — request accepted.
- `inst_sram_data_ok`  in  1  — read data valid.
- `inst_sram_rdata`  in  32  — fetched instruction.
- `IF_ready_go`  out  1  — a correct instruction is presented this cycle.
- `IFreg_valid`  out  1  — the stage holds a live instruction.
- `IFreg_bus`  out  64  — `{inst[63:32], pc[31:0]}`.
- `IFreg_excep`  out  1  — fetch exception flag (ADEF).

## Operation
**Redirect event.** R = `wb_ex | ertn_flush | (br_taken & ID_allow_in)`.
- Target priority: `wb_ex` → `ex_entry`; then `ertn_flush` → `era`; then branch → `br_target`.
- `br_taken` is honoured only while `ID_allow_in`=1. A branch stalled in decode therefore redirects exactly once.

**Registers.**
- `fetch_pc` (32).
- `state` ∈ {S_REQ, S_WAIT, S_HOLD}.
- `discard` (1).
- `inst_buf` (32).

**S_REQ**
- `inst_sram_req`=1.
- On `addr_ok`: go to S_WAIT.
- If R in the same cycle as `addr_ok`: set `discard`=1 and `fetch_pc`=target.
- If R without `addr_ok`: set `fetch_pc`=target and stay; the new address is seen next cycle.

**S_WAIT**
- On `data_ok` with `discard`=1: drop the data, clear `discard`, go to S_REQ.
- On `data_ok` with `discard`=0:
  - `ID_allow_in`=1: transfer, `fetch_pc`+=4, go to S_REQ.
  - otherwise: `inst_buf`=`rdata`, go to S_HOLD.
- R in S_WAIT: `discard`=1, `fetch_pc`=target.
- R together with `data_ok`: drop the data, go to S_REQ at the target.

**S_HOLD**
- `IF_ready_go`=1 and `inst` comes from `inst_buf`.
- On `ID_allow_in`: `fetch_pc`+=4, go to S_REQ.
- On R: drop `inst_buf`, `fetch_pc`=target, go to S_REQ.

**Outputs.**
- `IF_ready_go` = (S_WAIT & `data_ok` & ~`discard`) | S_HOLD, forced to 0 in any R cycle.
- `inst` = `rdata` in S_WAIT, `inst_buf` in S_HOLD.
- `IFreg_valid` = ~`discard` & ~R & (S_WAIT | S_HOLD).
- Transfer occurs when `IF_ready_go & ID_allow_in`.
- PC arithmetic is modulo 2^32; 32'hfffffffc + 4 wraps to 0.

## Timing
- **Reset values:** `state`=S_REQ, `fetch_pc`=`RESET_PC`, `discard`=0, `inst_buf`=0.
  - Outputs during reset: `inst_sram_req`=0, `IF_ready_go`=0, `IFreg_valid`=0, `IFreg_excep`=0.
  - The first request appears in the first cycle after `reset` drops.
- **Latency:** minimum is `req`/`addr_ok` in cycle N and `data_ok` with transfer in N+1. Peak throughput is 1 instruction per 2 cycles.
- **Outstanding requests:** never more than one; `inst_sram_req`=0 in S_WAIT and S_HOLD.
- **Reset mid-operation:** returns to reset values next cycle. A later `data_ok` for a pre-reset request must not occur; the memory is reset on the same `reset`.
- **Simultaneous `wb_ex` and `br_taken`:** `wb_ex` wins.

## Configuration
**`IF_ADEF_EN` defined:**
- In S_REQ with `fetch_pc[1:0]`≠0, no request is issued.
- The stage moves to S_HOLD with `inst_buf`=0 and `IFreg_excep`=1.
- It is handed to decode as a normal instruction.

**`IF_ADEF_EN` undefined:**
- `IFreg_excep` is tied 0.
- The address is sent unchecked.

## Test plan
- **Reset fetch:** release `reset`, RAM answers `addr_ok` immediately and `data_ok` next cycle, `ID_allow_in`=1 → addresses 1c000000, 1c000004, 1c000008 fetched, one transfer every 2 cycles, `IFreg_bus` pc fields match.
- **Decode stall:** `ID_allow_in`=0 for 5 cycles after `data_ok` → S_HOLD with `IF_ready_go`=1 and `inst` stable, no new `req`; release → next `req` to pc+4.
- **Branch in S_WAIT:** `br_taken`=1, target 1c000100, `ID_allow_in`=1, `data_ok` delayed 3 cycles → returned data discarded, `IFreg_valid`=0, next `req` addr=1c000100.
- **Stalled branch:** `br_taken` high for 3 cycles with `ID_allow_in`=0, then 1 → exactly one redirect, and the target instruction is not killed after arriving.
- **Exception over branch:** `wb_ex`=1 with `ex_entry`=1c008000 in the same cycle as `br_taken` → next fetch at 1c008000.
- **ADEF (`IF_ADEF_EN`):** `br_target`=1c000102 → no `req`; transfer with `IFreg_excep`=1, `inst`=0, pc=1c000102.

Source files
------------

// File: rtl/if_fetch_if.sv
// Instruction-SRAM request/response bundle between the fetch stage (master)
// and the instruction memory (slave).
interface if_fetch_if;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  modport master (
    output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
           inst_sram_addr, inst_sram_wdata,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
  );

  modport slave (
    input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
           inst_sram_addr, inst_sram_wdata,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
  );
endinterface

// File: rtl/if_fetch.sv
// LoongArch IF stage: owns fetch PC, one outstanding SRAM read, redirect/cancel.
// Optional fetch-address exception (ADEF) enabled by defining IF_ADEF_EN.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ID_allow_in,
  input  logic [32:0] BR_BUS,
  input  logic        wb_ex,
  input  logic [31:0] ex_entry,
  input  logic        ertn_flush,
  input  logic [31:0] era,
  if_fetch_if.master  inst_sram,
  output logic        IF_ready_go,
  output logic        IFreg_valid,
  output logic [63:0] IFreg_bus,
  output logic        IFreg_excep
);

  localparam int unsigned PC_W   = 32;
  localparam int unsigned INST_W = 32;
  localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
  logic               discard_q, discard_d;
  logic [INST_W-1:0]  inst_buf_q, inst_buf_d;

  logic               br_taken;
  logic [PC_W-1:0]    br_target;
  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;
  logic               adef;
  logic [INST_W-1:0]  inst;

  assign br_taken  = BR_BUS[0];
  assign br_target = BR_BUS[32:1];

  // A stalled branch in decode only redirects on the cycle decode accepts.
  always_comb begin
    redirect    = wb_ex | ertn_flush | (br_taken & ID_allow_in);
    redirect_pc = br_target;
    if (wb_ex)           redirect_pc = ex_entry;
    else if (ertn_flush) redirect_pc = era;
  end

`ifdef IF_ADEF_EN
  logic excep_q, excep_d;

  assign adef = (fetch_pc_q[1:0] != 2'b00);

  always_comb begin
    excep_d = excep_q;
    if (state_q == S_REQ && adef && !redirect)
      excep_d = 1'b1;
    else if (state_q == S_HOLD && (redirect || ID_allow_in))
      excep_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) excep_q <= 1'b0;
    else       excep_q <= excep_d;
  end

  assign IFreg_excep = ~reset & excep_q & (state_q == S_HOLD);
`else
  assign adef        = 1'b0;
  assign IFreg_excep = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;
    inst_buf_d = inst_buf_q;

    case (state_q)
      S_REQ: begin
        if (adef) begin
          if (redirect) begin
            fetch_pc_d = redirect_pc;
          end else begin
            state_d    = S_HOLD;
            inst_buf_d = '0;
          end
        end else if (inst_sram.inst_sram_addr_ok) begin
          state_d = S_WAIT;
          if (redirect) begin
            discard_d  = 1'b1;
            fetch_pc_d = redirect_pc;
          end
        end else if (redirect) begin
          fetch_pc_d = redirect_pc;
        end
      end

      S_WAIT: begin
        if (inst_sram.inst_sram_data_ok) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = S_REQ;
            if (redirect) fetch_pc_d = redirect_pc;
          end else if (redirect) begin
            state_d    = S_REQ;
            fetch_pc_d = redirect_pc;
          end else if (ID_allow_in) begin
            state_d    = S_REQ;
            fetch_pc_d = fetch_pc_q + PC_STEP;
          end else begin
            state_d    = S_HOLD;
            inst_buf_d = inst_sram.inst_sram_rdata;
          end
        end else if (redirect) begin
          discard_d  = 1'b1;
          fetch_pc_d = redirect_pc;
        end
      end

      S_HOLD: begin
        if (redirect) begin
          state_d    = S_REQ;
          fetch_pc_d = redirect_pc;
        end else if (ID_allow_in) begin
          state_d    = S_REQ;
          fetch_pc_d = fetch_pc_q + PC_STEP;
        end
      end

      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_REQ;
      fetch_pc_q <= RESET_PC;
      discard_q  <= 1'b0;
      inst_buf_q <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
      inst_buf_q <= inst_buf_d;
    end
  end

  // Read-only SRAM master; request only while idle and the address is legal.
  assign inst_sram.inst_sram_req   = ~reset & (state_q == S_REQ) & ~adef;
  assign inst_sram.inst_sram_wr    = 1'b0;
  assign inst_sram.inst_sram_size  = 2'b10;
  assign inst_sram.inst_sram_wstrb = 4'b0000;
  assign inst_sram.inst_sram_wdata = '0;
  assign inst_sram.inst_sram_addr  = fetch_pc_q;

  assign inst = (state_q == S_HOLD) ? inst_buf_q : inst_sram.inst_sram_rdata;

  assign IF_ready_go = ~reset & ~redirect &
                       (((state_q == S_WAIT) & inst_sram.inst_sram_data_ok & ~discard_q) |
                        (state_q == S_HOLD));
  assign IFreg_valid = ~reset & ~redirect & ~discard_q &
                       ((state_q == S_WAIT) | (state_q == S_HOLD));
  assign IFreg_bus   = {inst, fetch_pc_q};

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed cycle table plus randomized run
// against a program-order PC model and a latency-randomized memory.
module tb_if_fetch;

  localparam logic [31:0] RP   = 32'h1c00_0000;
  localparam logic [31:0] EXE  = 32'h1c00_8000;
  localparam logic [31:0] ERA  = 32'h1c00_0200;

  logic        clk;
  logic        reset;
  logic        ID_allow_in;
  logic [32:0] BR_BUS;
  logic        wb_ex;
  logic [31:0] ex_entry;
  logic        ertn_flush;
  logic [31:0] era;
  logic        IF_ready_go;
  logic        IFreg_valid;
  logic [63:0] IFreg_bus;
  logic        IFreg_excep;

  if_fetch_if bus ();

  if_fetch #(.RESET_PC(RP)) dut (
    .clk         (clk),
    .reset       (reset),
    .ID_allow_in (ID_allow_in),
    .BR_BUS      (BR_BUS),
    .wb_ex       (wb_ex),
    .ex_entry    (ex_entry),
    .ertn_flush  (ertn_flush),
    .era         (era),
    .inst_sram   (bus),
    .IF_ready_go (IF_ready_go),
    .IFreg_valid (IFreg_valid),
    .IFreg_bus   (IFreg_bus),
    .IFreg_excep (IFreg_excep)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst, alw, aok, dok, brt;
    logic [31:0] tgt;
    logic        wbx, ert;
    logic [31:0] rda;
    logic        e_req;
    logic [31:0] e_pc;
    logic        e_rg, e_vld;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t v(input logic rst, alw, aok, dok, brt, input logic [31:0] tgt,
                             input logic wbx, ert, input logic [31:0] rda,
                             input logic e_req, input logic [31:0] e_pc,
                             input logic e_rg, e_vld);
    vec_t r;
    r.rst = rst; r.alw = alw; r.aok = aok; r.dok = dok; r.brt = brt; r.tgt = tgt;
    r.wbx = wbx; r.ert = ert; r.rda = rda;
    r.e_req = e_req; r.e_pc = e_pc; r.e_rg = e_rg; r.e_vld = e_vld;
    return r;
  endfunction

  task automatic drive(input logic rst, alw, aok, dok, brt, input logic [31:0] tgt,
                       input logic wbx, ert, input logic [31:0] rda);
    reset                 = rst;
    ID_allow_in           = alw;
    bus.inst_sram_addr_ok = aok;
    bus.inst_sram_data_ok = dok;
    bus.inst_sram_rdata   = rda;
    BR_BUS                = {tgt, brt};
    wb_ex                 = wbx;
    ertn_flush            = ert;
  endtask

  // Random-phase state
  logic [31:0] exp_pc;
  logic        pending;
  logic [31:0] pend_addr;
  int          cnt;
  int          idle;

  initial begin
    logic        r_alw, r_aok, r_dok, r_brt, r_wbx, r_ert, r_rst, redir;
    logic [31:0] r_tgt, tgt_pc, r_rda;

    ex_entry = EXE;
    era      = ERA;
    drive(1, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0);

    //         rst alw aok dok brt tgt           wbx ert rda            req pc            rg vld
    vq.push_back(v(1, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0,         0, RP,            0, 0));
    vq.push_back(v(1, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0,         0, RP,            0, 0));
    vq.push_back(v(0, 1, 1, 0, 0, 32'h0,         0, 0, 32'h0,         1, RP,            0, 0));
    vq.push_back(v(0, 1, 0, 1, 0, 32'h0,         0, 0, mem_word(RP),  0, RP,            1, 1));
    vq.push_back(v(0, 1, 1, 0, 0, 32'h0,         0, 0, 32'h0,         1, RP+4,          0, 0));
    vq.push_back(v(0, 1, 0, 1, 0, 32'h0,         0, 0, mem_word(RP+4),0, RP+4,          1, 1));
    vq.push_back(v(0, 1, 1, 0, 0, 32'h0,         0, 0, 32'h0,         1, RP+8,          0, 0));
    vq.push_back(v(0, 0, 0, 1, 0, 32'h0,         0, 0, mem_word(RP+8),0, RP+8,          1, 1));
    for (int i = 0; i < 4; i++)
      vq.push_back(v(0, 0, 0, 0, 0, 32'h0,       0, 0, 32'hdeadbeef,  0, RP+8,          1, 1));
    vq.push_back(v(0, 1, 0, 0, 0, 32'h0,         0, 0, 32'h0,         0, RP+8,          1, 1));
    vq.push_back(v(0, 1, 1, 0, 0, 32'h0,         0, 0, 32'h0,         1, RP+12,         0, 0));
    vq.push_back(v(0, 1, 0, 0, 1, 32'h1c000100,  0, 0, 32'h0,         0, RP+12,         0, 0));
    vq.push_back(v(0, 1, 0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h1c000100,  0, 0));
    vq.push_back(v(0, 1, 0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h1c000100,  0, 0));
    vq.push_back(v(0, 1, 0, 1, 0, 32'h0,         0, 0, mem_word(RP+12),0,32'h1c000100,  0, 0));
    vq.push_back(v(0, 1, 1, 0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h1c000100,  0, 0));
    vq.push_back(v(0, 1, 0, 1, 0, 32'h0,         0, 0, mem_word(32'h1c000100), 0, 32'h1c000100, 1, 1));
    vq.push_back(v(0, 1, 0, 0, 1, 32'h1c000300,  1, 0, 32'h0,         1, 32'h1c000104,  0, 0));
    vq.push_back(v(0, 1, 1, 0, 0, 32'h0,         0, 0, 32'h0,         1, EXE,           0, 0));
    vq.push_back(v(0, 1, 0, 1, 0, 32'h0,         0, 0, mem_word(EXE), 0, EXE,           1, 1));
    vq.push_back(v(0, 0, 1, 0, 0, 32'h0,         0, 1, 32'h0,         1, EXE+4,         0, 0));
    vq.push_back(v(0, 1, 0, 1, 0, 32'h0,         0, 0, mem_word(EXE+4),0, ERA,          0, 0));
    vq.push_back(v(0, 1, 1, 0, 0, 32'h0,         0, 0, 32'h0,         1, ERA,           0, 0));
    vq.push_back(v(0, 1, 0, 1, 1, 32'hfffffffc,  0, 0, mem_word(ERA), 0, ERA,           0, 0));
    vq.push_back(v(0, 1, 1, 0, 0, 32'h0,         0, 0, 32'h0,         1, 32'hfffffffc,  0, 0));
    vq.push_back(v(0, 1, 0, 1, 0, 32'h0,         0, 0, mem_word(32'hfffffffc), 0, 32'hfffffffc, 1, 1));
    vq.push_back(v(0, 1, 1, 0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0,         0, 0));
    vq.push_back(v(0, 0, 0, 1, 1, 32'h1c000400,  0, 0, mem_word(32'h0), 0, 32'h0,       1, 1));
    vq.push_back(v(0, 0, 0, 0, 1, 32'h1c000400,  0, 0, 32'h0,         0, 32'h0,         1, 1));
    vq.push_back(v(0, 0, 0, 0, 1, 32'h1c000400,  0, 0, 32'h0,         0, 32'h0,         1, 1));
    vq.push_back(v(0, 1, 0, 0, 1, 32'h1c000400,  0, 0, 32'h0,         0, 32'h0,         0, 0));
    vq.push_back(v(0, 1, 1, 0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h1c000400,  0, 0));
    vq.push_back(v(0, 1, 0, 1, 0, 32'h0,         0, 0, mem_word(32'h1c000400), 0, 32'h1c000400, 1, 1));
    vq.push_back(v(0, 1, 0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h1c000404,  0, 0));
    vq.push_back(v(0, 1, 1, 0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h1c000404,  0, 0));
    vq.push_back(v(1, 1, 0, 0, 0, 32'h0,         0, 0, 32'h0,         0, RP,            0, 0));
    vq.push_back(v(0, 1, 0, 0, 0, 32'h0,         0, 0, 32'h0,         1, RP,            0, 0));

    foreach (vq[i]) begin
      @(posedge clk); #1;
      drive(vq[i].rst, vq[i].alw, vq[i].aok, vq[i].dok, vq[i].brt, vq[i].tgt,
            vq[i].wbx, vq[i].ert, vq[i].rda);
      #1;
      chk($sformatf("tbl%0d_req", i), 64'(bus.inst_sram_req), 64'(vq[i].e_req));
      chk($sformatf("tbl%0d_ready_go", i), 64'(IF_ready_go), 64'(vq[i].e_rg));
      chk($sformatf("tbl%0d_valid", i), 64'(IFreg_valid), 64'(vq[i].e_vld));
      if (!vq[i].rst) begin
        chk($sformatf("tbl%0d_addr", i), 64'(bus.inst_sram_addr), 64'(vq[i].e_pc));
        chk($sformatf("tbl%0d_excep", i), 64'(IFreg_excep), 64'(1'b0));
      end
      if (vq[i].e_rg)
        chk($sformatf("tbl%0d_bus", i), IFreg_bus, {mem_word(vq[i].e_pc), vq[i].e_pc});
    end

    chk("const_wr", 64'(bus.inst_sram_wr), 64'(1'b0));
    chk("const_size", 64'(bus.inst_sram_size), 64'(2'b10));
    chk("const_wstrb", 64'(bus.inst_sram_wstrb), 64'(4'b0));
    chk("const_wdata", 64'(bus.inst_sram_wdata), 64'(32'h0));

`ifdef IF_ADEF_EN
    @(posedge clk); #1; drive(1, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
    @(posedge clk); #1; drive(0, 1, 0, 0, 1, 32'h1c000102, 0, 0, 32'h0);
    @(posedge clk); #1; drive(0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
    #1; chk("adef_no_req", 64'(bus.inst_sram_req), 64'(1'b0));
    @(posedge clk); #1; drive(0, 1, 0, 0, 0, 32'h0, 0, 0, 32'h12345678);
    #1;
    chk("adef_ready_go", 64'(IF_ready_go), 64'(1'b1));
    chk("adef_excep", 64'(IFreg_excep), 64'(1'b1));
    chk("adef_bus", IFreg_bus, {32'h0, 32'h1c000102});
`endif

    // Randomized run: transfers must follow program order from the last redirect.
    @(posedge clk); #1; drive(1, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
    exp_pc  = RP;
    pending = 1'b0;
    cnt     = 0;
    idle    = 0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      r_rst = ($urandom_range(0, 599) == 0);
      r_dok = !r_rst && pending && (cnt == 0);
      r_rda = r_dok ? mem_word(pend_addr) : $urandom;
      r_aok = !r_rst && bus.inst_sram_req && !pending && ($urandom_range(0, 2) != 0);
      r_alw = ($urandom_range(0, 3) != 0);
      r_brt = ($urandom_range(0, 15) == 0);
      r_tgt = RP | ($urandom & 32'h0000_0ffc);
      r_wbx = ($urandom_range(0, 63) == 0);
      r_ert = ($urandom_range(0, 63) == 0);
      ex_entry = RP | ($urandom & 32'h0000_fff0);
      era      = RP | ($urandom & 32'h0000_fffc);
      drive(r_rst, r_alw, r_aok, r_dok, r_brt, r_tgt, r_wbx, r_ert, r_rda);
      #1;
      if (r_rst) begin
        chk("rnd_reset_req", 64'(bus.inst_sram_req), 64'(1'b0));
        chk("rnd_reset_ready_go", 64'(IF_ready_go), 64'(1'b0));
        exp_pc  = RP;
        pending = 1'b0;
        idle    = 0;
        continue;
      end
      if (bus.inst_sram_req)
        chk("rnd_single_outstanding", 64'(pending), 64'(1'b0));
      redir  = r_wbx | r_ert | (r_brt & r_alw);
      tgt_pc = r_wbx ? ex_entry : (r_ert ? era : r_tgt);
      if (redir) begin
        chk("rnd_no_xfer_on_redirect", 64'(IF_ready_go), 64'(1'b0));
        chk("rnd_invalid_on_redirect", 64'(IFreg_valid), 64'(1'b0));
        exp_pc = tgt_pc;
        idle   = 0;
      end else if (IF_ready_go && r_alw) begin
        chk("rnd_xfer", IFreg_bus, {mem_word(exp_pc), exp_pc});
        exp_pc = exp_pc + 32'd4;
        idle   = 0;
      end else begin
        idle++;
        if (idle > 80) begin
          chk("rnd_liveness_idle_cycles", 64'(idle), 64'(80));
          idle = 0;
        end
      end
      if (r_dok) pending = 1'b0;
      else if (pending && cnt > 0) cnt--;
      if (bus.inst_sram_req && r_aok) begin
        pending   = 1'b1;
        pend_addr = bus.inst_sram_addr;
        cnt       = $urandom_range(0, 3);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
